quad_adc_interface: RTL and testbench
=====================================

QUAD_ADC_INTERFACE -- requirements
Module: quad_adc_interface

Interface
REQ-001 Parameter DATA_WIDTH, default 14: sample width in bits; only value 14 is supported (7 bit-pairs plus 1 pad pair per frame).
REQ-002 DATA_CLK  input  1  sole clock, ADC bit clock; one DDR bit-pair per lane on each edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on rising DATA_CLK.
REQ-004 FRAME_CLK  input  1  ADC frame clock, period 4 DATA_CLK cycles, 50% duty; treated as data sampled by DATA_CLK, not as a clock.
REQ-005 CH_X_A  input  1  serial lane A: odd sample bits, MSB first (d13, d11 ... d1, then pad).
REQ-006 CH_X_B  input  1  serial lane B: even sample bits, MSB first (d12, d10 ... d0, then pad).
REQ-007 CH_X_DATA  output  14  last complete deserialized sample, unsigned, registered.
REQ-008 DATA_VALID  output  1  one-DATA_CLK-cycle pulse when CH_X_DATA updates.
REQ-009 FRAME_ERROR  output  1  one-DATA_CLK-cycle pulse when a frame is aborted.

Function
REQ-010 One clock domain: lane capture on both DATA_CLK edges; all other state and outputs on rising DATA_CLK only.
REQ-011 Falling-edge registers FA/FB capture CH_X_A/CH_X_B on every falling DATA_CLK edge; they are not reset.
REQ-012 On each rising edge, FRAME_CLK is registered into frame_d; frame start = FRAME_CLK==1 and frame_d==0.
REQ-013 Frame slot timing: slot 0 = rising edge of frame start, slot 1 = next falling, alternating; slots 0-6 carry data, slot 7 is pad and is ignored.
REQ-014 At frame start: shift register <= {CH_X_A, CH_X_B}; pair counter <= 0; state COLLECT.
REQ-015 In COLLECT on each non-start rising edge: shift register <= {shift register, FA, FB, CH_X_A, CH_X_B}; counter increments.
REQ-016 On the 3rd rising edge after frame start (counter 0->3 transition), the block SHALL load CH_X_DATA <= {d13..d0} (14 bits just completed), pulse DATA_VALID, and return to IDLE.
REQ-017 Latency: CH_X_DATA/DATA_VALID change on the same rising edge that samples d1/d0; previous value held until then.
REQ-018 Bit mapping: CH_X_DATA[13-2k] from lane A and [12-2k] from lane B for pair k = 0..6.
REQ-019 IDLE: no shifting, outputs hold; a frame start moves to COLLECT per REQ-014.
REQ-020 Frame start while in COLLECT with counter < 3: discard partial word, pulse FRAME_ERROR, restart collection per REQ-014 (simultaneous event: restart wins, no DATA_VALID).
REQ-021 FRAME_CLK staying high or low indefinitely: no frame start, no output, no error.
REQ-022 Pad slot contents (slot 7) never affect CH_X_DATA.

Reset
REQ-023 While RESET=1 at a rising edge: CH_X_DATA=0, DATA_VALID=0, FRAME_ERROR=0, counter=0, shift register=0, state IDLE, frame_d=1.
REQ-024 frame_d reset to 1 so a FRAME_CLK already high at reset release is not taken as a frame start; first capture begins at the next 0->1 transition.
REQ-025 Reset asserted mid-frame aborts the frame silently (no DATA_VALID, no FRAME_ERROR).

Verification
REQ-026 DATA_CLK 50 ns period, FRAME_CLK 200 ns period rising 12 ns after a DATA_CLK falling edge, lanes changing 12 ns after each DATA_CLK edge; samples 0x0001..0x0007 sent back-to-back -> CH_X_DATA = 0x0001..0x0007 in order, one DATA_VALID pulse per 200 ns, FRAME_ERROR never asserted.
REQ-027 Sample 0x2AAA then 0x1555 -> CH_X_DATA 0x2AAA then 0x1555 (lane A all-1 vs lane B all-1 mapping check).
REQ-028 Sample 0x3FFF with pad bits forced to 1 -> CH_X_DATA = 0x3FFF; then 0x0000 with pad 1 -> 0x0000.
REQ-029 Frame start injected 2 rising edges after a previous start -> FRAME_ERROR one-cycle pulse, no DATA_VALID, following full frame 0x0123 -> CH_X_DATA = 0x0123.
REQ-030 RESET asserted mid-frame with FRAME_CLK high, released -> outputs 0, no DATA_VALID until the next FRAME_CLK 0->1, then next sample decoded correctly.

Source files
------------

// File: rtl/quad_adc_interface.sv
`default_nettype none
// ============================================================================
//  Module      : quad_adc_interface
//  Description : Deserialises one ADC channel delivered as two DDR lanes
//                (A = odd bits, B = even bits, MSB first) framed by FRAME_CLK.
//                Emits a registered 14-bit sample with a one-cycle valid
//                pulse, and flags frames aborted by an early frame start.
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_adc_interface #(
    parameter int DATA_WIDTH = 14
) (
    input  logic                  DATA_CLK,
    input  logic                  RESET,
    input  logic                  FRAME_CLK,
    input  logic                  CH_X_A,
    input  logic                  CH_X_B,
    output logic [DATA_WIDTH-1:0] CH_X_DATA,
    output logic                  DATA_VALID,
    output logic                  FRAME_ERROR
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // Rising edge at which the final pair (d1/d0) is on the lanes.
    localparam logic [1:0] C_LAST_CNT = 2'd2;

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    error_q, error_d;
    logic                    frame_dly_q;
    logic                    fa_q, fb_q;
    logic                    w_frame_start;

    // Falling-edge half of the DDR capture; consumed on the following rising edge.
    always_ff @(negedge DATA_CLK) begin
        fa_q <= CH_X_A;
        fb_q <= CH_X_B;
    end

    // A frame begins on the first rising edge that sees FRAME_CLK high after low.
    assign w_frame_start = FRAME_CLK & ~frame_dly_q;

    // Next-state: restart on frame start, otherwise shift two pairs per rising edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        error_d = 1'b0;

        if (w_frame_start) begin
            // An early start discards the partial word; it also wins over a
            // completion on the same edge, so no valid is produced then.
            if ((state_q == ST_COLLECT) && (cnt_q != 2'd3)) begin
                error_d = 1'b1;
            end
            shift_d = {{(DATA_WIDTH-2){1'b0}}, CH_X_A, CH_X_B};
            cnt_d   = 2'd0;
            state_d = ST_COLLECT;
        end else if (state_q == ST_COLLECT) begin
            shift_d = {shift_q[DATA_WIDTH-5:0], fa_q, fb_q, CH_X_A, CH_X_B};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == C_LAST_CNT) begin
                // The pad pair that follows on the falling edge is never used.
                data_d  = shift_d;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    // State and output registers; frame delay resets high so a FRAME_CLK
    // already high at reset release is not mistaken for a frame start.
    always_ff @(posedge DATA_CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            frame_dly_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            frame_dly_q <= FRAME_CLK;
        end
    end

    assign CH_X_DATA   = data_q;
    assign DATA_VALID  = valid_q;
    assign FRAME_ERROR = error_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_adc_interface.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quad_adc_interface
//  Description : Self-checking bench for quad_adc_interface. A serialiser
//                drives samples onto the two DDR lanes; the expected output
//                is simply the sample that was sent by a completed frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_adc_interface;

    logic        DATA_CLK  = 1'b0;
    logic        RESET     = 1'b1;
    logic        FRAME_CLK = 1'b0;
    logic        CH_X_A    = 1'b0;
    logic        CH_X_B    = 1'b0;
    logic [13:0] CH_X_DATA;
    logic        DATA_VALID;
    logic        FRAME_ERROR;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [13:0] model_data = 14'd0;   // last sample a completed frame delivered

    quad_adc_interface #(.DATA_WIDTH(14)) dut (
        .DATA_CLK    (DATA_CLK),
        .RESET       (RESET),
        .FRAME_CLK   (FRAME_CLK),
        .CH_X_A      (CH_X_A),
        .CH_X_B      (CH_X_B),
        .CH_X_DATA   (CH_X_DATA),
        .DATA_VALID  (DATA_VALID),
        .FRAME_ERROR (FRAME_ERROR)
    );

    // 50 ns bit clock
    always #25 DATA_CLK = ~DATA_CLK;

    // Serialise one 200 ns frame: even slots follow a falling edge, odd slots
    // a rising edge, each 12 ns later. Outputs are checked 1 ns after every
    // rising edge: valid only at the edge sampling d1/d0, error only at the
    // frame-start edge when the previous frame was cut short.
    task automatic send_frame(input logic [13:0] d, input logic pa, input logic pb,
                              input logic exp_err);
        logic exp_v;
        logic exp_e;
        for (int s = 0; s < 8; s++) begin
            if (s % 2 == 0) begin
                @(negedge DATA_CLK);
                #12;
            end else begin
                @(posedge DATA_CLK);
                #1;
                exp_v = (s == 7);
                exp_e = exp_err && (s == 1);
                if (s == 7) model_data = d;
                if (DATA_VALID !== exp_v) begin
                    n_fail++;
                    $display("FAIL frame valid slot%0d: got %b want %b", s, DATA_VALID, exp_v);
                end
                n_cmp++;
                if (FRAME_ERROR !== exp_e) begin
                    n_fail++;
                    $display("FAIL frame error slot%0d: got %b want %b", s, FRAME_ERROR, exp_e);
                end
                n_cmp++;
                if (CH_X_DATA !== model_data) begin
                    n_fail++;
                    $display("FAIL frame data slot%0d: got %h want %h", s, CH_X_DATA, model_data);
                end
                n_cmp++;
                #11;
            end
            if (s == 0) FRAME_CLK = 1'b1;
            if (s == 4) FRAME_CLK = 1'b0;
            if (s < 7) begin
                CH_X_A = d[13-2*s];
                CH_X_B = d[12-2*s];
            end else begin
                CH_X_A = pa;
                CH_X_B = pb;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge DATA_CLK);
        #1;
        if (CH_X_DATA !== 14'd0) begin
            n_fail++;
            $display("FAIL reset data: got %h want 0000", CH_X_DATA);
        end
        n_cmp++;
        if (DATA_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset valid: got %b want 0", DATA_VALID);
        end
        n_cmp++;
        if (FRAME_ERROR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset error: got %b want 0", FRAME_ERROR);
        end
        n_cmp++;
        #11;
        RESET = 1'b0;
    endtask

    // FRAME_CLK held low with toggling lanes: nothing must happen.
    task automatic test_idle();
        repeat (6) begin
            @(posedge DATA_CLK);
            #1;
            if ((DATA_VALID !== 1'b0) || (FRAME_ERROR !== 1'b0) || (CH_X_DATA !== model_data)) begin
                n_fail++;
                $display("FAIL idle: got v=%b e=%b d=%h want v=0 e=0 d=%h",
                         DATA_VALID, FRAME_ERROR, CH_X_DATA, model_data);
            end
            n_cmp++;
            #11;
            CH_X_A = 1'($urandom);
            CH_X_B = 1'($urandom);
        end
    endtask

    task automatic test_sequence();
        for (int i = 1; i <= 7; i++) send_frame(14'(i), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_patterns();
        send_frame(14'h2AAA, 1'b0, 1'b0, 1'b0);
        send_frame(14'h1555, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_pad();
        send_frame(14'h3FFF, 1'b1, 1'b1, 1'b0);
        send_frame(14'h0000, 1'b1, 1'b1, 1'b0);
    endtask

    // Start a frame, then start another 'gap' rising edges later.
    task automatic test_frame_error(input int gap, input logic [13:0] d);
        @(negedge DATA_CLK);
        #12;
        FRAME_CLK = 1'b1;
        CH_X_A = 1'($urandom);
        CH_X_B = 1'($urandom);
        @(posedge DATA_CLK);
        #12;
        FRAME_CLK = 1'b0;
        CH_X_A = 1'($urandom);
        CH_X_B = 1'($urandom);
        for (int k = 1; k < gap; k++) begin
            @(negedge DATA_CLK);
            #12;
            CH_X_A = 1'($urandom);
            CH_X_B = 1'($urandom);
            @(posedge DATA_CLK);
            #1;
            if ((DATA_VALID !== 1'b0) || (FRAME_ERROR !== 1'b0)) begin
                n_fail++;
                $display("FAIL abort gap%0d edge%0d: got v=%b e=%b want v=0 e=0",
                         gap, k, DATA_VALID, FRAME_ERROR);
            end
            n_cmp++;
            #11;
            CH_X_A = 1'($urandom);
            CH_X_B = 1'($urandom);
        end
        send_frame(d, 1'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        logic [13:0] d;
        d = 14'($urandom);
        @(negedge DATA_CLK);
        #12;
        FRAME_CLK = 1'b1;
        CH_X_A = d[13];
        CH_X_B = d[12];
        @(posedge DATA_CLK);
        #12;
        CH_X_A = d[11];
        CH_X_B = d[10];
        @(negedge DATA_CLK);
        #12;
        CH_X_A = d[9];
        CH_X_B = d[8];
        @(posedge DATA_CLK);
        #12;
        RESET = 1'b1;
        @(posedge DATA_CLK);
        #1;
        model_data = 14'd0;
        if ((CH_X_DATA !== 14'd0) || (DATA_VALID !== 1'b0) || (FRAME_ERROR !== 1'b0)) begin
            n_fail++;
            $display("FAIL midreset: got d=%h v=%b e=%b want d=0000 v=0 e=0",
                     CH_X_DATA, DATA_VALID, FRAME_ERROR);
        end
        n_cmp++;
        #11;
        RESET = 1'b0;
        // FRAME_CLK still high after release: must not count as a start
        repeat (4) begin
            @(posedge DATA_CLK);
            #1;
            if ((CH_X_DATA !== 14'd0) || (DATA_VALID !== 1'b0) || (FRAME_ERROR !== 1'b0)) begin
                n_fail++;
                $display("FAIL postreset: got d=%h v=%b e=%b want d=0000 v=0 e=0",
                         CH_X_DATA, DATA_VALID, FRAME_ERROR);
            end
            n_cmp++;
            #11;
            CH_X_A = 1'($urandom);
            CH_X_B = 1'($urandom);
        end
        FRAME_CLK = 1'b0;
        @(posedge DATA_CLK);
        send_frame(14'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            send_frame(14'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_sequence();
        test_patterns();
        test_pad();
        test_frame_error(2, 14'h0123);
        test_frame_error(3, 14'($urandom));
        send_frame(14'($urandom), 1'b1, 1'b0, 1'b0);
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100 us");
        $fatal(1);
    end

endmodule
`default_nettype wire
